// File: rtl/id_ex_stage_if.sv
// Bundle of decode-side, forwarding and execute-side signals around the
// ID/EX register. Decode/forwarding/execute logic uses the master view and
// the stage itself uses the slave view.
interface id_ex_stage_if #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3,
   parameter int CTRL_W     = 3,
   parameter int CNT_W      = 16
);
   // decode side
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [REG_ADDR_W-1:0] in_rs_addr;
   logic [REG_ADDR_W-1:0] in_rt_addr;
   logic [DATA_W-1:0]     in_rs_data;
   logic [DATA_W-1:0]     in_rt_data;
   logic [DATA_W-1:0]     in_imm;
   logic                  in_alu_src;
   logic [CTRL_W-1:0]     in_alu_control;
   logic [REG_ADDR_W-1:0] in_rd_addr;
   logic                  in_reg_write;
   // forwarding network
   logic                  fwd_ex_valid;
   logic [REG_ADDR_W-1:0] fwd_ex_addr;
   logic [DATA_W-1:0]     fwd_ex_data;
   logic                  fwd_mem_valid;
   logic [REG_ADDR_W-1:0] fwd_mem_addr;
   logic [DATA_W-1:0]     fwd_mem_data;
   // execute side
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     srcA;
   logic [DATA_W-1:0]     srcB;
   logic [CTRL_W-1:0]     aluControl;
   logic [REG_ADDR_W-1:0] out_rd_addr;
   logic                  out_reg_write;
   logic [CNT_W-1:0]      stall_cnt;

   modport master (
      output flush, in_valid, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data,
             in_imm, in_alu_src, in_alu_control, in_rd_addr, in_reg_write,
             fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
             fwd_mem_valid, fwd_mem_addr, fwd_mem_data, out_ready,
      input  in_ready, out_valid, srcA, srcB, aluControl, out_rd_addr,
             out_reg_write, stall_cnt
   );

   modport slave (
      input  flush, in_valid, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data,
             in_imm, in_alu_src, in_alu_control, in_rd_addr, in_reg_write,
             fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
             fwd_mem_valid, fwd_mem_addr, fwd_mem_data, out_ready,
      output in_ready, out_valid, srcA, srcB, aluControl, out_rd_addr,
             out_reg_write, stall_cnt
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 16-bit ALU. Operands are resolved
// through EX-then-MEM forwarding at capture, and re-resolved while the entry
// is held so a stalled instruction picks up results that arrive late.
module id_ex_stage #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3,
   parameter int CTRL_W     = 3,
   parameter int CNT_W      = 16
) (
   input logic          clk,
   input logic          rst_n,
   id_ex_stage_if.slave bus
);

   // Forwarding priority: EX/MEM result first, then MEM/WB, else the default.
   function automatic logic signed [DATA_W-1:0] fwdSelect(
      input logic [REG_ADDR_W-1:0]    addr,
      input logic signed [DATA_W-1:0] dflt,
      input logic                     exValid,
      input logic [REG_ADDR_W-1:0]    exAddr,
      input logic signed [DATA_W-1:0] exData,
      input logic                     memValid,
      input logic [REG_ADDR_W-1:0]    memAddr,
      input logic signed [DATA_W-1:0] memData
   );
      if (exValid && exAddr == addr)
         return exData;
      else if (memValid && memAddr == addr)
         return memData;
      else
         return dflt;
   endfunction

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + 1'b1;
   endfunction

   logic                     vld_p0;
   logic                     regWrite_p0;
   logic [CNT_W-1:0]         stallCnt_p0;
   logic [REG_ADDR_W-1:0]    rsAddr_p0;
   logic [REG_ADDR_W-1:0]    rtAddr_p0;
   logic                     aluSrc_p0;
   logic signed [DATA_W-1:0] srcA_p0;
   logic signed [DATA_W-1:0] srcB_p0;
   logic [CTRL_W-1:0]        aluCtrl_p0;
   logic [REG_ADDR_W-1:0]    rdAddr_p0;

   logic                     inReady;
   logic                     accept;
   logic                     consume;
   logic                     holding;
   logic signed [DATA_W-1:0] rsCapture;
   logic signed [DATA_W-1:0] rtCapture;
   logic signed [DATA_W-1:0] rsRefresh;
   logic signed [DATA_W-1:0] rtRefresh;

   assign inReady = !vld_p0 || bus.out_ready;
   assign accept  = bus.in_valid && inReady && !bus.flush;
   assign consume = vld_p0 && bus.out_ready;
   assign holding = vld_p0 && !bus.out_ready;

   // Register 0 always reads as zero at capture; otherwise forward or use RF.
   assign rsCapture = (bus.in_rs_addr == '0) ? '0 :
      fwdSelect(bus.in_rs_addr, bus.in_rs_data,
                bus.fwd_ex_valid, bus.fwd_ex_addr, bus.fwd_ex_data,
                bus.fwd_mem_valid, bus.fwd_mem_addr, bus.fwd_mem_data);
   assign rtCapture = (bus.in_rt_addr == '0) ? '0 :
      fwdSelect(bus.in_rt_addr, bus.in_rt_data,
                bus.fwd_ex_valid, bus.fwd_ex_addr, bus.fwd_ex_data,
                bus.fwd_mem_valid, bus.fwd_mem_addr, bus.fwd_mem_data);

   // Held operands only change on a forwarding hit; register 0 never does.
   assign rsRefresh = (rsAddr_p0 == '0) ? srcA_p0 :
      fwdSelect(rsAddr_p0, srcA_p0,
                bus.fwd_ex_valid, bus.fwd_ex_addr, bus.fwd_ex_data,
                bus.fwd_mem_valid, bus.fwd_mem_addr, bus.fwd_mem_data);
   assign rtRefresh = (aluSrc_p0 || rtAddr_p0 == '0) ? srcB_p0 :
      fwdSelect(rtAddr_p0, srcB_p0,
                bus.fwd_ex_valid, bus.fwd_ex_addr, bus.fwd_ex_data,
                bus.fwd_mem_valid, bus.fwd_mem_addr, bus.fwd_mem_data);

   // ---- ID -> EX boundary ----

   // Control state: entry validity, write enable and the stall counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0      <= 1'b0;
         regWrite_p0 <= 1'b0;
         stallCnt_p0 <= '0;
      end else begin
         if (holding)
            stallCnt_p0 <= satInc(stallCnt_p0);
         if (bus.flush) begin
            vld_p0      <= 1'b0;
            regWrite_p0 <= 1'b0;
         end else if (accept) begin
            vld_p0      <= 1'b1;
            regWrite_p0 <= bus.in_reg_write;
         end else if (consume) begin
            vld_p0      <= 1'b0;
            regWrite_p0 <= 1'b0;
         end
      end
   end

   // Payload: capture on accept, re-resolve operands while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsAddr_p0  <= '0;
         rtAddr_p0  <= '0;
         aluSrc_p0  <= 1'b0;
         srcA_p0    <= '0;
         srcB_p0    <= '0;
         aluCtrl_p0 <= '0;
         rdAddr_p0  <= '0;
      end else if (!bus.flush) begin
         if (accept) begin
            rsAddr_p0  <= bus.in_rs_addr;
            rtAddr_p0  <= bus.in_rt_addr;
            aluSrc_p0  <= bus.in_alu_src;
            srcA_p0    <= rsCapture;
            srcB_p0    <= bus.in_alu_src ? bus.in_imm : rtCapture;
            aluCtrl_p0 <= bus.in_alu_control;
            rdAddr_p0  <= bus.in_rd_addr;
         end else if (holding) begin
            srcA_p0 <= rsRefresh;
            srcB_p0 <= rtRefresh;
         end
      end
   end

   assign bus.in_ready      = inReady;
   assign bus.out_valid     = vld_p0;
   assign bus.srcA          = srcA_p0;
   assign bus.srcB          = srcB_p0;
   assign bus.aluControl    = aluCtrl_p0;
   assign bus.out_rd_addr   = rdAddr_p0;
   assign bus.out_reg_write = vld_p0 && regWrite_p0;
   assign bus.stall_cnt     = stallCnt_p0;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, issue, forwarding priority, stall
// refresh, flush, counter saturation (narrow counter instance) and async reset.
module tb_id_ex_stage;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   id_ex_stage_if #(.DATA_W(16), .REG_ADDR_W(3), .CTRL_W(3), .CNT_W(16)) ifc ();
   id_ex_stage_if #(.DATA_W(16), .REG_ADDR_W(3), .CTRL_W(3), .CNT_W(4))  ifs ();

   id_ex_stage #(.DATA_W(16), .REG_ADDR_W(3), .CTRL_W(3), .CNT_W(16)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc.slave)
   );

   id_ex_stage #(.DATA_W(16), .REG_ADDR_W(3), .CTRL_W(3), .CNT_W(4)) dutSat (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifs.slave)
   );

   // 10 ns clock, rising edge active
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idleInputs();
      ifc.flush = 0; ifc.in_valid = 0; ifc.in_rs_addr = 0; ifc.in_rt_addr = 0;
      ifc.in_rs_data = 0; ifc.in_rt_data = 0; ifc.in_imm = 0; ifc.in_alu_src = 0;
      ifc.in_alu_control = 0; ifc.in_rd_addr = 0; ifc.in_reg_write = 0;
      ifc.fwd_ex_valid = 0; ifc.fwd_ex_addr = 0; ifc.fwd_ex_data = 0;
      ifc.fwd_mem_valid = 0; ifc.fwd_mem_addr = 0; ifc.fwd_mem_data = 0;
      ifc.out_ready = 0;
      ifs.flush = 0; ifs.in_valid = 0; ifs.in_rs_addr = 0; ifs.in_rt_addr = 0;
      ifs.in_rs_data = 0; ifs.in_rt_data = 0; ifs.in_imm = 0; ifs.in_alu_src = 0;
      ifs.in_alu_control = 0; ifs.in_rd_addr = 0; ifs.in_reg_write = 0;
      ifs.fwd_ex_valid = 0; ifs.fwd_ex_addr = 0; ifs.fwd_ex_data = 0;
      ifs.fwd_mem_valid = 0; ifs.fwd_mem_addr = 0; ifs.fwd_mem_data = 0;
      ifs.out_ready = 0;
   endtask

   task automatic issue(input logic [2:0] rs, input logic [2:0] rt,
                        input logic [15:0] rsData, input logic [15:0] rtData,
                        input logic aluSrc, input logic [15:0] imm,
                        input logic [2:0] ctrl, input logic [2:0] rd);
      ifc.in_valid       = 1;
      ifc.in_rs_addr     = rs;
      ifc.in_rt_addr     = rt;
      ifc.in_rs_data     = rsData;
      ifc.in_rt_data     = rtData;
      ifc.in_alu_src     = aluSrc;
      ifc.in_imm         = imm;
      ifc.in_alu_control = ctrl;
      ifc.in_rd_addr     = rd;
      ifc.in_reg_write   = 1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 0;
      idleInputs();

      // 1. reset then idle
      repeat (2) @(negedge clk);
      checkEq("rst_out_valid", ifc.out_valid, 0);
      checkEq("rst_srcA", ifc.srcA, 0);
      checkEq("rst_srcB", ifc.srcB, 0);
      checkEq("rst_aluControl", ifc.aluControl, 0);
      checkEq("rst_rd_addr", ifc.out_rd_addr, 0);
      checkEq("rst_reg_write", ifc.out_reg_write, 0);
      checkEq("rst_stall_cnt", ifc.stall_cnt, 0);
      checkEq("rst_in_ready", ifc.in_ready, 1);
      rst_n = 1;

      // 2. back-to-back add then sub, out_ready held high
      ifc.out_ready = 1;
      issue(3'd1, 3'd2, 16'd5, 16'd7, 1'b0, 16'd0, 3'b010, 3'd3);
      @(negedge clk);
      checkEq("b2b_valid0", ifc.out_valid, 1);
      checkEq("b2b_srcA0", ifc.srcA, 16'd5);
      checkEq("b2b_srcB0", ifc.srcB, 16'd7);
      checkEq("b2b_ctrl0", ifc.aluControl, 3'b010);
      checkEq("b2b_rd0", ifc.out_rd_addr, 3'd3);
      checkEq("b2b_wr0", ifc.out_reg_write, 1);
      issue(3'd4, 3'd5, 16'd9, 16'd4, 1'b0, 16'd0, 3'b110, 3'd6);
      @(negedge clk);
      checkEq("b2b_valid1", ifc.out_valid, 1);
      checkEq("b2b_ctrl1", ifc.aluControl, 3'b110);
      checkEq("b2b_srcA1", ifc.srcA, 16'd9);
      checkEq("b2b_srcB1", ifc.srcB, 16'd4);
      checkEq("b2b_rd1", ifc.out_rd_addr, 3'd6);
      ifc.in_valid = 0;
      @(negedge clk);
      checkEq("drain_valid", ifc.out_valid, 0);
      checkEq("drain_wr", ifc.out_reg_write, 0);

      // 3. forwarding priority
      issue(3'd3, 3'd2, 16'h0011, 16'h0022, 1'b0, 16'd0, 3'b010, 3'd1);
      ifc.fwd_ex_valid = 1;  ifc.fwd_ex_addr = 3'd3;  ifc.fwd_ex_data = 16'h00AA;
      ifc.fwd_mem_valid = 1; ifc.fwd_mem_addr = 3'd3; ifc.fwd_mem_data = 16'h00BB;
      @(negedge clk);
      checkEq("fwd_ex_first", ifc.srcA, 16'h00AA);
      checkEq("fwd_rt_rf", ifc.srcB, 16'h0022);
      ifc.fwd_ex_valid = 0;
      @(negedge clk);
      checkEq("fwd_mem_second", ifc.srcA, 16'h00BB);
      ifc.in_rs_addr = 0;
      ifc.fwd_ex_valid = 1; ifc.fwd_ex_addr = 0; ifc.fwd_mem_addr = 0;
      @(negedge clk);
      checkEq("fwd_r0_zero", ifc.srcA, 16'h0000);
      ifc.fwd_mem_valid = 1; ifc.fwd_mem_addr = 3'd2; ifc.fwd_mem_data = 16'h0C0C;
      ifc.fwd_ex_valid = 0;
      @(negedge clk);
      checkEq("fwd_rt_mem", ifc.srcB, 16'h0C0C);
      ifc.in_valid = 0; ifc.fwd_ex_valid = 0; ifc.fwd_mem_valid = 0;
      @(negedge clk);

      // 4a. stall with refresh, alu_src=0
      ifc.out_ready = 0;
      issue(3'd1, 3'd2, 16'h0010, 16'h0022, 1'b0, 16'd0, 3'b010, 3'd4);
      @(negedge clk);
      ifc.in_valid = 0;
      checkEq("stall_captured", ifc.srcB, 16'h0022);
      checkEq("stall_in_ready", ifc.in_ready, 0);
      for (int c = 1; c <= 4; c++) begin
         if (c == 2) begin
            ifc.fwd_mem_valid = 1; ifc.fwd_mem_addr = 3'd2; ifc.fwd_mem_data = 16'h1234;
         end else begin
            ifc.fwd_mem_valid = 0;
         end
         @(negedge clk);
      end
      checkEq("refresh_srcB", ifc.srcB, 16'h1234);
      checkEq("refresh_srcA_kept", ifc.srcA, 16'h0010);
      checkEq("refresh_ctrl_kept", ifc.aluControl, 3'b010);
      checkEq("stall_cnt4", ifc.stall_cnt, 4);
      checkEq("stall_in_ready2", ifc.in_ready, 0);
      ifc.out_ready = 1;
      #1;
      checkEq("ready_comb", ifc.in_ready, 1);
      @(negedge clk);
      checkEq("consume_valid", ifc.out_valid, 0);
      checkEq("consume_cnt", ifc.stall_cnt, 4);

      // 4b. stall with immediate operand: srcB must not refresh
      ifc.out_ready = 0;
      issue(3'd1, 3'd2, 16'h0010, 16'h0022, 1'b1, 16'hFFF0, 3'b010, 3'd4);
      @(negedge clk);
      ifc.in_valid = 0;
      for (int c = 1; c <= 4; c++) begin
         ifc.fwd_mem_valid = (c == 2);
         ifc.fwd_mem_addr = 3'd2; ifc.fwd_mem_data = 16'h1234;
         @(negedge clk);
      end
      ifc.fwd_mem_valid = 0;
      checkEq("imm_no_refresh", ifc.srcB, 16'hFFF0);
      checkEq("stall_cnt8", ifc.stall_cnt, 8);

      // 5. flush beats a same-cycle accept while holding
      ifc.out_ready = 1;
      @(negedge clk);
      ifc.out_ready = 0;
      issue(3'd1, 3'd2, 16'h0001, 16'h0002, 1'b0, 16'd0, 3'b001, 3'd5);
      @(negedge clk);
      checkEq("flush_pre_valid", ifc.out_valid, 1);
      issue(3'd3, 3'd4, 16'h0003, 16'h0004, 1'b0, 16'd0, 3'b000, 3'd7);
      ifc.flush = 1;
      @(negedge clk);
      checkEq("flush_valid", ifc.out_valid, 0);
      checkEq("flush_wr", ifc.out_reg_write, 0);
      checkEq("flush_in_ready", ifc.in_ready, 1);
      checkEq("flush_keeps_cnt", ifc.stall_cnt, 9);
      ifc.flush = 0; ifc.in_valid = 0;
      @(negedge clk);
      checkEq("flush_dropped", ifc.out_valid, 0);

      // 6a. saturation on the 4-bit counter instance
      ifs.in_valid = 1; ifs.in_reg_write = 1; ifs.in_rd_addr = 3'd5;
      ifs.in_alu_control = 3'b111; ifs.out_ready = 0;
      @(negedge clk);
      ifs.in_valid = 0;
      repeat (20) @(negedge clk);
      checkEq("sat_cnt", ifs.stall_cnt, 4'hF);
      checkEq("sat_valid", ifs.out_valid, 1);

      // 6b. asynchronous reset between edges, mid-stall
      issue(3'd2, 3'd3, 16'h0055, 16'h0066, 1'b0, 16'd0, 3'b111, 3'd2);
      @(negedge clk);
      ifc.in_valid = 0;
      @(negedge clk);
      checkEq("pre_rst_valid", ifc.out_valid, 1);
      #2 rst_n = 0;
      #1;
      checkEq("arst_valid", ifc.out_valid, 0);
      checkEq("arst_srcA", ifc.srcA, 0);
      checkEq("arst_srcB", ifc.srcB, 0);
      checkEq("arst_wr", ifc.out_reg_write, 0);
      checkEq("arst_rd", ifc.out_rd_addr, 0);
      checkEq("arst_ctrl", ifc.aluControl, 0);
      checkEq("arst_cnt", ifc.stall_cnt, 0);
      checkEq("arst_sat_cnt", ifs.stall_cnt, 0);
      checkEq("arst_sat_valid", ifs.out_valid, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      checkEq("post_rst_ready", ifc.in_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that directly feeds the 16-bit ALU.
- Captures one decoded instruction and resolves operand hazards through an EX-first, then MEM, forwarding network.
- Drives the ALU's srcA, srcB and aluControl from registered state, and passes destination information downstream.
- Uses a valid/ready handshake, a synchronous flush, and a saturating stall counter for performance monitoring.

Parameters:
- DATA_W, 16, operand/result width.
- REG_ADDR_W, 3, register-file address width. Register 0 reads as zero.
- CTRL_W, 3, ALU control width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of the held and incoming instruction.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_rs_addr  in  REG_ADDR_W  source A register.
- in_rt_addr  in  REG_ADDR_W  source B register.
- in_rs_data  in  DATA_W  register-file value for rs.
- in_rt_data  in  DATA_W  register-file value for rt.
- in_imm  in  DATA_W  sign-extended immediate.
- in_alu_src  in  1  1 selects in_imm as srcB.
- in_alu_control  in  CTRL_W  ALU opcode (010 add, 110 sub, 000 and, 001 or, 111 slt).
- in_rd_addr  in  REG_ADDR_W  destination register.
- in_reg_write  in  1  instruction writes rd.
- fwd_ex_valid  in  1  EX/MEM result forwarding enable.
- fwd_ex_addr  in  REG_ADDR_W  EX/MEM destination.
- fwd_ex_data  in  DATA_W  EX/MEM result (ALU output).
- fwd_mem_valid  in  1  MEM/WB forwarding enable.
- fwd_mem_addr  in  REG_ADDR_W  MEM/WB destination.
- fwd_mem_data  in  DATA_W  MEM/WB result.
- out_valid  out  1  srcA/srcB/aluControl are valid.
- out_ready  in  1  execute stage consumes this cycle.
- srcA  out  DATA_W  ALU operand A.
- srcB  out  DATA_W  ALU operand B.
- aluControl  out  CTRL_W  ALU opcode.
- out_rd_addr  out  REG_ADDR_W  destination passthrough.
- out_reg_write  out  1  write enable, forced 0 whenever out_valid=0.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- **Reset** (rst_n=0, asynchronous): all registered outputs are 0, including out_valid, srcA, srcB, aluControl=000, out_rd_addr, out_reg_write and stall_cnt. Held addresses and flags are also 0.
- **Ready:** in_ready = !out_valid || out_ready. This is combinational and does not depend on in_valid.
- **Accept:** in_valid && in_ready && !flush. The stage registers the instruction next edge and sets out_valid=1. Latency is 1 cycle from accept to out_valid.
- **Consume without accept:** out_valid && out_ready with no accept clears out_valid next edge.
- **Back-to-back:** consume and accept in the same cycle replaces the entry, with no bubble. Full throughput is one instruction per cycle.
- **Operand resolution at capture, per source (rs and rt):**
  - addr==0 gives 0.
  - else fwd_ex_valid && fwd_ex_addr==addr gives fwd_ex_data.
  - else fwd_mem_valid && fwd_mem_addr==addr gives fwd_mem_data.
  - else the register-file data.
- **srcB selection:** srcB = in_imm if in_alu_src=1, else the resolved rt.
- **Held-entry refresh:** while out_valid && !out_ready && !flush, each held source is re-resolved every cycle against the forwarding inputs, using the same priority.
  - A source is updated only on a match; otherwise it retains its value.
  - srcB is never refreshed when the held alu_src=1.
  - Register 0 is never refreshed.
- **Flush:** on the next edge out_valid=0 and out_reg_write=0, and any same-cycle input is dropped.
  - Flush has priority over accept, consume and refresh.
  - Data registers may retain their values.
- **Stall counter:** stall_cnt increments each cycle with out_valid && !out_ready. It saturates at all-ones and does not wrap. Flush does not clear it; only reset does.
- **Output stability:** outputs change only on clk edges, except in_ready. While out_valid=1 and out_ready=0, aluControl and out_rd_addr are stable; srcA/srcB change only through refresh.
- **Reset mid-stall:** the entry is discarded immediately and the counter clears.

Test Plan:
1. Reset then idle: rst_n low, in_valid=0 → all outputs 0, in_ready=1, stall_cnt=0.
2. Back-to-back issue: out_ready=1; accept add r1,r2 (rs_data=5, rt_data=7) then sub → cycle+1 srcA=5, srcB=7, aluControl=010; next cycle aluControl=110; out_valid continuous.
3. Forward priority: rs=3, fwd_ex={1,3,0x00AA}, fwd_mem={1,3,0x00BB}, rs_data=0x0011 → srcA=0x00AA. Same with fwd_ex_valid=0 → 0x00BB. rs=0 with all matches → srcA=0.
4. Stall refresh: hold with out_ready=0 for 4 cycles, rt=2, alu_src=0; cycle 2 fwd_mem={1,2,0x1234} → srcB becomes 0x1234, stall_cnt=4, in_ready=0. Repeat with alu_src=1, imm=0xFFF0 → srcB stays 0xFFF0.
5. Flush vs accept: in_valid=1 and flush=1 in the same cycle while holding → next cycle out_valid=0, out_reg_write=0, in_ready=1.
6. Saturation and async reset: force CNT_W=4, stall 20 cycles → stall_cnt=15. Assert rst_n mid-stall between edges → outputs 0 immediately.
